// File: rtl/go_decode.sv
// TicTacToe win-display sequencer: latches the gameover word once per game,
// expands it to a cell mask and blinks then holds the winning cells.
module go_decode #(
  parameter int BLINK_DIV     = 25_000_000,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] gameover,
  input  logic       clear,
  output logic [8:0] cell_mask,
  output logic [8:0] highlight,
  output logic [1:0] winner,
  output logic       win_evt,
  output logic       busy
);

  localparam int DW = $clog2(BLINK_DIV);
  localparam int TW = $clog2(FLASH_TOGGLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TOG_LAST = TW'(FLASH_TOGGLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FLASH,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    mask_q, mask_d;
  logic [1:0]    win_q, win_d;
  logic          phase_q, phase_d;
  logic          evt_q, evt_d;
  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] tog_q, tog_d;

  function automatic logic [8:0] line_cells(
    input logic [7:0] l
  );
    logic [8:0] m;
    m = '0;
    if (l[0]) m |= 9'b000_000_111;
    if (l[1]) m |= 9'b000_111_000;
    if (l[2]) m |= 9'b111_000_000;
    if (l[3]) m |= 9'b001_001_001;
    if (l[4]) m |= 9'b010_010_010;
    if (l[5]) m |= 9'b100_100_100;
    if (l[6]) m |= 9'b100_010_001;
    if (l[7]) m |= 9'b001_010_100;
    return m;
  endfunction

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    win_d   = win_q;
    phase_d = phase_q;
    div_d   = div_q;
    tog_d   = tog_q;
    evt_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      mask_d  = '0;
      win_d   = '0;
      phase_d = 1'b0;
      div_d   = '0;
      tog_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gameover[9]) begin
            state_d = FLASH;
            mask_d  = line_cells(gameover[7:0]);
            win_d   = gameover[8] ? 2'b10 : 2'b01;
            phase_d = 1'b1;
            div_d   = '0;
            tog_d   = '0;
            evt_d   = 1'b1;
          end
        end
        FLASH: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            phase_d = ~phase_q;
            tog_d   = tog_q + 1'b1;
            // last toggle lands steady-lit in HOLD
            if (tog_q == TOG_LAST) begin
              state_d = HOLD;
              phase_d = 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        HOLD: begin
          div_d = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      win_q   <= '0;
      phase_q <= 1'b0;
      evt_q   <= 1'b0;
      div_q   <= '0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      win_q   <= win_d;
      phase_q <= phase_d;
      evt_q   <= evt_d;
      div_q   <= div_d;
      tog_q   <= tog_d;
    end
  end

  assign cell_mask = mask_q;
  assign highlight = mask_q & {9{phase_q}};
  assign winner    = win_q;
  assign win_evt   = evt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/go_decode.md
# go_decode

Win-display sequencer for the TicTacToe datapath. It consumes the 10-bit gameover word from the win-detect encoder and captures the result once per game. It expands the line bits back into a 9-cell board mask and drives a blinking, then steady, highlight of the winning cells for the VGA/LED board renderer, plus a winner code for the status display. The captured result is held until the game controller issues a clear.

## Interface
- BLINK_DIV, 25_000_000: clk cycles per blink half-period (≥2).
- FLASH_TOGGLES, 6: phase toggles in FLASH before entering HOLD (even, ≥2).
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- gameover  input  10  [9]=game over, [8]=P2 won (valid only with [9]), [7:0]=line flags: 0–2 rows top→bottom, 3–5 columns left→right, 6 diagonal cell0→cell8, 7 diagonal cell2→cell6.
- clear  input  1  synchronous new-game request, sampled every cycle.
- cell_mask  output  9  latched winning cells; cell k = row*3+col, row-major.
- highlight  output  9  cell_mask gated by the blink phase; this is what the renderer draws.
- winner  output  2  00 none, 01 P1, 10 P2; 11 never driven.
- win_evt  output  1  one-cycle pulse on capture.
- busy  output  1  high when the state is FLASH or HOLD.

## Operation
- States: IDLE, FLASH, HOLD.
- Line→cell mapping:
  - line0 {0,1,2}, line1 {3,4,5}, line2 {6,7,8}
  - line3 {0,3,6}, line4 {1,4,7}, line5 {2,5,8}
  - line6 {0,4,8}, line7 {2,4,6}
- cell_mask is the OR over all set line flags. Two simultaneous lines (e.g. a fork completion) give a 5-cell mask.
- IDLE, clear=0, gameover[9]=1: next edge captures cell_mask and winner (gameover[8] ? 10 : 01), sets phase=1, zeroes div_cnt and tog_cnt, pulses win_evt, and enters FLASH.
- IDLE, gameover[9]=0: no action. gameover[8] without [9] is ignored.
- FLASH:
  - div_cnt counts 0..BLINK_DIV-1. On the terminal count it wraps to 0, phase inverts and tog_cnt increments.
  - When the toggle that makes tog_cnt reach FLASH_TOGGLES occurs, the state goes to HOLD with phase=1.
- HOLD: highlight=cell_mask steady. div_cnt is frozen at 0.
- After capture, gameover is not re-sampled until the block returns to IDLE. Later changes to gameover do not alter the latched outputs.
- clear=1 in any state: next edge goes to IDLE and zeroes cell_mask, winner, phase, counters, win_evt and busy. clear has priority over capture in the same cycle.
- If gameover[9] is still high on the first IDLE cycle after clear, it is captured again. The game controller clears the board on the same edge as clear.
- highlight = cell_mask & {9{phase}}. It is 0 in IDLE.
- Counter widths: div_cnt is $clog2(BLINK_DIV) bits; tog_cnt is $clog2(FLASH_TOGGLES+1) bits. Neither counter may overflow.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - cell_mask=0, highlight=0, winner=00, win_evt=0, busy=0.
  - phase=0, counters=0.
- Capture latency: with gameover[9] sampled at edge E0, all outputs are valid after E0. highlight is lit the first cycle after E0.
- Blink schedule:
  - phase toggles at E0+n·BLINK_DIV for n=1..FLASH_TOGGLES.
  - highlight is dark in the intervals [E0+(2m-1)·BLINK_DIV, E0+2m·BLINK_DIV).
  - HOLD is entered at E0+FLASH_TOGGLES·BLINK_DIV.
- win_evt is high for exactly the cycle after E0.
- clear acts with 1-cycle latency.
- Reset asserted mid-FLASH or mid-HOLD takes effect immediately, without waiting for clk.

## Test plan
- **P1 top-row win.** BLINK_DIV=4, FLASH_TOGGLES=6. Drive gameover=10'b10_0000_0001.
  - After the capture edge: cell_mask=9'b000000111, winner=01, win_evt high 1 cycle, busy=1.
- **Blink timing.** Same setup as the previous scenario.
  - highlight=0 during cycles E0+4..7, 12..15 and 20..23; equals cell_mask otherwise.
  - State is HOLD at E0+24, and highlight stays at 9'b000000111 for 100 cycles.
- **P2 double line.** Drive gameover=10'b11_0100_0001 (line0 and line6).
  - cell_mask=9'b100010111, winner=10.
  - Changing gameover to 0 afterwards leaves the outputs unchanged.
- **Clear mid-FLASH.** Assert clear at E0+6.
  - Next cycle all outputs are 0 and busy=0; there is no capture while gameover=0.
- **Clear and capture collision.** In IDLE, assert clear=1 and gameover[9]=1 on the same cycle.
  - No capture and no win_evt on that edge.
  - Capture occurs on the following edge if gameover[9] remains high.
- **Reset mid-HOLD.** Pulse rst_n low for 3 ns between clock edges.
  - Outputs are 0 immediately.
  - After release the block re-captures a held gameover[9]=1 on the first edge.
